// File: rtl/cordic_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_phase_gen
//  Description : NCO phase accumulator and angle front end for a pipelined
//                CORDIC sine/cosine stage. It folds the full-circle phase
//                into [-pi/2, +pi/2] and emits a signed Q2.6 radian angle.
//                A cosine-negate flag is delayed so that it lines up with
//                the CORDIC results.
//                Optional build macro CORDIC_PHASE_DITHER_EN adds LFSR
//                phase dither at the fold input only.
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_phase_gen #(
   parameter int PHASE_W    = 16,
   parameter int CORDIC_LAT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PHASE_W-1:0] ftw,
   input  logic               phase_load,
   input  logic [PHASE_W-1:0] phase_init,
   output logic [7:0]         angle_out,
   output logic               angle_valid,
   output logic               cos_neg,
   output logic               res_valid
);

   // The product of the folded phase and the pi scale factor fits in this width.
   localparam int c_PROD_W = PHASE_W + 16;

   // Quarter and half circle, expressed in phase units, at fold width.
   localparam logic signed [PHASE_W:0] c_Q     = (PHASE_W+1)'(2**(PHASE_W-2));
   localparam logic signed [PHASE_W:0] c_H     = (PHASE_W+1)'(2**(PHASE_W-1));
   localparam logic signed [PHASE_W:0] c_NEG_H = -c_H;

   // round(pi * 2^13); the rounding offset gives round-half-up on the final shift.
   localparam logic signed [c_PROD_W-1:0] c_SCALE = c_PROD_W'(25736);
   localparam logic signed [c_PROD_W-1:0] c_HALF  = c_PROD_W'(2**(PHASE_W+5));

   // ------------------------------------------------------------------------
   // Stage 0: phase accumulator
   // ------------------------------------------------------------------------
   logic [PHASE_W-1:0] r_acc;
   logic               r_v0;
   logic               w_sample;

   assign w_sample = phase_load | en;

   // Load overrides advance; wrap is the natural modulo of the adder.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_acc <= '0;
         r_v0  <= 1'b0;
      end else begin
         r_v0 <= w_sample;
         if (phase_load) begin
            r_acc <= phase_init;
         end else if (en) begin
            r_acc <= r_acc + ftw;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Fold input (optionally dithered; the accumulator itself is never touched)
   // ------------------------------------------------------------------------
   logic [PHASE_W-1:0] w_fold_in;

`ifdef CORDIC_PHASE_DITHER_EN
   logic [15:0] r_lfsr;
   logic        w_lfsr_fb;

   assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, advanced once per new sample.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_lfsr <= 16'hACE1;
      end else if (w_sample) begin
         r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      end
   end

   assign w_fold_in = r_acc + PHASE_W'(r_lfsr[PHASE_W-10:0]);
`else
   assign w_fold_in = r_acc;
`endif

   // ------------------------------------------------------------------------
   // Stage A: fold into [-Q, +Q]; sine is preserved, cosine changes sign
   // ------------------------------------------------------------------------
   logic signed [PHASE_W:0] w_s;
   logic signed [PHASE_W:0] w_fold;
   logic                    w_fold_neg;
   logic signed [PHASE_W:0] r_sa;
   logic                    r_nega;
   logic                    r_va;

   assign w_s = signed'({w_fold_in[PHASE_W-1], w_fold_in});

   // Reflect about +/-pi/2; exactly +/-Q stays unfolded.
   always_comb begin
      w_fold     = w_s;
      w_fold_neg = 1'b0;
      if (w_s > c_Q) begin
         w_fold     = c_H - w_s;
         w_fold_neg = 1'b1;
      end else if (w_s < -c_Q) begin
         w_fold     = c_NEG_H - w_s;
         w_fold_neg = 1'b1;
      end
   end

   // Register the folded phase and its cosine-negate flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_sa   <= '0;
         r_nega <= 1'b0;
         r_va   <= 1'b0;
      end else begin
         r_sa   <= w_fold;
         r_nega <= w_fold_neg;
         r_va   <= r_v0;
      end
   end

   // ------------------------------------------------------------------------
   // Stage B: scale phase units to Q2.6 radians
   // ------------------------------------------------------------------------
   logic signed [c_PROD_W-1:0] w_sa_ext;
   logic signed [c_PROD_W-1:0] w_prod;
   logic signed [c_PROD_W-1:0] w_round;
   logic [7:0]                 r_angle;
   logic                       r_angle_valid;
   logic                       r_negb;

   assign w_sa_ext = {{15{r_sa[PHASE_W]}}, r_sa};
   assign w_prod   = w_sa_ext * c_SCALE;
   assign w_round  = w_prod + c_HALF;

   // Angle only changes on valid samples so it holds across idle cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_angle       <= '0;
         r_angle_valid <= 1'b0;
         r_negb        <= 1'b0;
      end else begin
         r_angle_valid <= r_va;
         r_negb        <= r_va & r_nega;
         if (r_va) begin
            r_angle <= 8'(w_round >>> (PHASE_W + 6));
         end
      end
   end

   // ------------------------------------------------------------------------
   // Flag delay line matching the CORDIC latency
   // ------------------------------------------------------------------------
   logic [CORDIC_LAT-1:0] r_dly_v;
   logic [CORDIC_LAT-1:0] r_dly_n;

   // Free-running shift register; every cycle moves one slot.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_dly_v <= '0;
         r_dly_n <= '0;
      end else begin
         r_dly_v[0] <= r_angle_valid;
         r_dly_n[0] <= r_negb;
         for (int i = 1; i < CORDIC_LAT; i++) begin
            r_dly_v[i] <= r_dly_v[i-1];
            r_dly_n[i] <= r_dly_n[i-1];
         end
      end
   end

   assign angle_out   = r_angle;
   assign angle_valid = r_angle_valid;
   assign cos_neg     = r_dly_n[CORDIC_LAT-1];
   assign res_valid   = r_dly_v[CORDIC_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_phase_gen
//  Description : Directed, table-driven bench for cordic_phase_gen
//                (PHASE_W=16, CORDIC_LAT=8, dither macro undefined).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cordic_phase_gen;

   localparam int PW  = 16;
   localparam int LAT = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [PW-1:0] ftw;
   logic          phase_load;
   logic [PW-1:0] phase_init;
   logic [7:0]    angle_out;
   logic          angle_valid;
   logic          cos_neg;
   logic          res_valid;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] h_ang [0:511];
   logic       h_av  [0:511];
   logic       h_cn  [0:511];
   logic       h_rv  [0:511];

   typedef struct {
      logic          ld;
      logic          en;
      logic [PW-1:0] ftw;
      logic [PW-1:0] init;
      int            ang;
      logic          neg;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   cordic_phase_gen #(
      .PHASE_W    (PW),
      .CORDIC_LAT (LAT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .ftw         (ftw),
      .phase_load  (phase_load),
      .phase_init  (phase_init),
      .angle_out   (angle_out),
      .angle_valid (angle_valid),
      .cos_neg     (cos_neg),
      .res_valid   (res_valid)
   );

   always #5 clk = ~clk;

   // One clock edge; outputs are sampled 1 ns after it and logged by edge number.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      h_ang[cyc] = angle_out;
      h_av[cyc]  = angle_valid;
      h_cn[cyc]  = cos_neg;
      h_rv[cyc]  = res_valid;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic idle();
      en         = 1'b0;
      phase_load = 1'b0;
      ftw        = '0;
      phase_init = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b, e, r, cnt;

      vecs[0]  = '{1'b1, 1'b0, 16'h0000, 16'h2000,   50, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 16'h0000, 16'h6000,   50, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 16'h0000, 16'h8000,    0, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 16'h0000, 16'h4000,  101, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'hC000, -101, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 16'h0000, 16'hF000,  -25, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 16'h1000, 16'h0000,    0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 16'h1000, 16'h0000,   25, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 16'h0000, 16'h7000,   25, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 16'h0000, 16'h9000,  -25, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 16'h0000, 16'h4001,  101, 1'b1};
      vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'hBFFF, -101, 1'b1};
      vecs[12] = '{1'b1, 1'b0, 16'h0000, 16'h0001,    0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 16'h0000, 16'hFFFF,    0, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 16'h1000, 16'hA000,  -50, 1'b1};

      // Reset, then idle: every output stays zero.
      rst = 1'b0;
      idle();
      repeat (3) begin
         tick();
         chk("reset outputs", int'({angle_out, angle_valid, cos_neg, res_valid}), 0);
      end
      rst = 1'b1;
      repeat (LAT + 4) begin
         tick();
         chk("idle outputs", int'({angle_out, angle_valid, cos_neg, res_valid}), 0);
      end

      // Table: back-to-back samples, one per cycle.
      b = cyc + 1;
      for (int i = 0; i < NV; i++) begin
         phase_load = vecs[i].ld;
         en         = vecs[i].en;
         ftw        = vecs[i].ftw;
         phase_init = vecs[i].init;
         tick();
      end
      idle();
      repeat (LAT + 4) tick();
      for (int i = 0; i < NV; i++) begin
         chk($sformatf("vec%0d angle_valid", i), int'(h_av[b+i+2]), 1);
         chk($sformatf("vec%0d angle_out", i), int'($signed(h_ang[b+i+2])), vecs[i].ang);
         chk($sformatf("vec%0d res_valid", i), int'(h_rv[b+i+2+LAT]), 1);
         chk($sformatf("vec%0d cos_neg", i), int'(h_cn[b+i+2+LAT]), int'(vecs[i].neg));
      end

      // Latency: a single load gives one-cycle pulses at +2 and +2+LAT.
      phase_load = 1'b1;
      phase_init = 16'h2000;
      tick();
      e = cyc;
      idle();
      repeat (LAT + 6) tick();
      cnt = 0;
      for (int k = e + 1; k <= cyc; k++) cnt += int'(h_av[k]);
      chk("latency angle_valid count", cnt, 1);
      chk("latency angle_valid position", int'(h_av[e+2]), 1);
      cnt = 0;
      for (int k = e + 1; k <= cyc; k++) cnt += int'(h_rv[k]);
      chk("latency res_valid count", cnt, 1);
      chk("latency res_valid position", int'(h_rv[e+2+LAT]), 1);

      // en gaps from a zero accumulator.
      rst = 1'b0;
      tick();
      rst = 1'b1;
      en  = 1'b1;
      ftw = 16'h1000;
      tick();
      e  = cyc;
      en = 1'b0;
      tick();
      en = 1'b1;
      tick();
      idle();
      repeat (4) tick();
      chk("gap valid0", int'(h_av[e+2]), 1);
      chk("gap valid1", int'(h_av[e+3]), 0);
      chk("gap valid2", int'(h_av[e+4]), 1);
      chk("gap angle0", int'($signed(h_ang[e+2])), 25);
      chk("gap angle hold", int'($signed(h_ang[e+3])), 25);
      chk("gap angle2", int'($signed(h_ang[e+4])), 50);

      // Reset mid-stream with continuous en.
      en  = 1'b1;
      ftw = 16'h1000;
      repeat (6) tick();
      rst = 1'b0;
      tick();
      r   = cyc;
      rst = 1'b1;
      repeat (LAT + 6) tick();
      idle();
      chk("midreset outputs at reset",
          int'({h_ang[r], h_av[r], h_cn[r], h_rv[r]}), 0);
      cnt = 0;
      for (int k = r + 1; k <= r + LAT + 2; k++) cnt += int'(h_rv[k]);
      chk("midreset res_valid quiet", cnt, 0);
      chk("midreset no stale valid", int'(h_av[r+1]) + int'(h_av[r+2]), 0);
      chk("midreset restart valid", int'(h_av[r+3]), 1);
      chk("midreset restart angle", int'($signed(h_ang[r+3])), 25);
      chk("midreset first res_valid", int'(h_rv[r+LAT+3]), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
